// File: rtl/gf_pkg.sv
// gf_pkg: constants shared between the hit FIFO and the gigafitter top.
//   GF_DATA_W    - default hit data width
//   GF_OP_W      - default opcode width
//   GF_EE_OPCODE - opcode marking an end-of-event word
//   fifo_op_e    - per-cycle FIFO operation, encoded as {pop, push}
package gf_pkg;

    localparam int unsigned GF_DATA_W = 23;
    localparam int unsigned GF_OP_W   = 5;
    localparam logic [GF_OP_W-1:0] GF_EE_OPCODE = 5'h1F;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage : gf_pkg

// File: rtl/gf_dpram.sv
// gf_dpram: simple dual-port storage for the hit FIFO.
//   clk_i   - clock, write and read both on the rising edge
//   rst_n_i - async active-low reset, clears the read register only
//   we_i    - write enable; waddr_i / wdata_i give location and word
//   re_i    - read enable; rdata_o loads mem[raddr_i] on the next edge
//   rdata_o - registered read data, holds its value when re_i is low
module gf_dpram #(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : gf_dpram

// File: rtl/gf_hit_fifo.sv
// gf_hit_fifo: hit FIFO with end-of-event accounting and upstream hold.
//   clk        - clock, rising edge
//   reset      - async active-low reset
//   opcode     - opcode of the incoming word
//   data_in    - data of the incoming word
//   ds         - data strobe, writes {opcode,data_in} unless full
//   re         - read request, pops unless empty
//   clr_ovf    - clears the sticky overflow flag (a drop the same cycle wins)
//   data_out   - popped word {opcode,data}, one cycle after the pop
//   valid      - data_out carries a freshly popped word
//   data_count - stored word count (registered)
//   empty/full - count==0 / count==DEPTH (registered)
//   hold       - back-pressure with HOLD_HI/HOLD_LO hysteresis
//   ee_count   - number of stored end-of-event words
//   overflow   - sticky, set by a write dropped while full
module gf_hit_fifo
    import gf_pkg::*;
#(
    parameter int unsigned     DATA_W     = GF_DATA_W,
    parameter int unsigned     OP_W       = GF_OP_W,
    parameter int unsigned     DEPTH_LOG2 = 10,
    parameter int unsigned     HOLD_HI    = (1 << DEPTH_LOG2) - 64,
    parameter int unsigned     HOLD_LO    = (1 << DEPTH_LOG2) / 2,
    parameter logic [OP_W-1:0] EE_OPCODE  = OP_W'(GF_EE_OPCODE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_W-1:0]        opcode,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   ds,
    input  logic                   re,
    input  logic                   clr_ovf,
    output logic [OP_W+DATA_W-1:0] data_out,
    output logic                   valid,
    output logic [DEPTH_LOG2:0]    data_count,
    output logic                   empty,
    output logic                   full,
    output logic                   hold,
    output logic [DEPTH_LOG2:0]    ee_count,
    output logic                   overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned WORD_W = OP_W + DATA_W;

    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      HOLD_HI_C = CNT_W'(HOLD_HI);
    localparam logic [CNT_W-1:0]      HOLD_LO_C = CNT_W'(HOLD_LO);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      ee_count_q, ee_count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  hold_q, hold_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;

    // One EE tag per storage slot so the popped word's opcode is known on
    // the pop edge itself; the RAM read data only arrives a cycle later.
    logic                  ee_tag_q [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ee_inc;
    logic                  ee_dec;
    fifo_op_e              fifo_op;

    always_comb begin
        wr_acc  = ds && !full_q;
        rd_acc  = re && !empty_q;
        ee_inc  = wr_acc && (opcode == EE_OPCODE);
        ee_dec  = rd_acc && ee_tag_q[rd_ptr_q];
        fifo_op = fifo_op_e'({rd_acc, wr_acc});

        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        unique case (fifo_op)
            FIFO_PUSH: count_d = count_q + CNT_ONE;
            FIFO_POP:  count_d = count_q - CNT_ONE;
            default:   count_d = count_q;
        endcase

        ee_count_d = ee_count_q;
        if (ee_inc && !ee_dec) begin
            ee_count_d = ee_count_q + CNT_ONE;
        end else if (ee_dec && !ee_inc) begin
            ee_count_d = ee_count_q - CNT_ONE;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);

        // Hysteresis works off the registered count, giving one cycle of lag.
        hold_d = hold_q;
        if (count_q >= HOLD_HI_C) begin
            hold_d = 1'b1;
        end else if (count_q <= HOLD_LO_C) begin
            hold_d = 1'b0;
        end

        ovf_d = ovf_q;
        if (ds && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        valid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ee_count_q <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            hold_q     <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ee_count_q <= ee_count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            ee_tag_q[wr_ptr_q] <= (opcode == EE_OPCODE);
        end
    end

    gf_dpram #(
        .WIDTH  (WORD_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .rst_n_i (reset),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i ({opcode, data_in}),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign valid      = valid_q;
    assign data_count = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign hold       = hold_q;
    assign ee_count   = ee_count_q;
    assign overflow   = ovf_q;

endmodule : gf_hit_fifo

// File: tb/tb_gf_hit_fifo.sv
// tb_gf_hit_fifo: directed and randomized bench for gf_hit_fifo
// (DEPTH_LOG2=4, HOLD_HI=12, HOLD_LO=4) with a queue-based reference model.
module tb_gf_hit_fifo;

    localparam int unsigned DW    = 23;
    localparam int unsigned OW    = 5;
    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned HI    = 12;
    localparam int unsigned LO    = 4;
    localparam int unsigned W     = OW + DW;
    localparam logic [OW-1:0] EE  = 5'h1F;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic [OW-1:0] opcode  = '0;
    logic [DW-1:0] data_in = '0;
    logic          ds      = 1'b0;
    logic          re      = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [W-1:0]  data_out;
    logic          valid;
    logic [DL:0]   data_count;
    logic          empty;
    logic          full;
    logic          hold;
    logic [DL:0]   ee_count;
    logic          overflow;

    always #5 clk = ~clk;

    gf_hit_fifo #(
        .DATA_W     (DW),
        .OP_W       (OW),
        .DEPTH_LOG2 (DL),
        .HOLD_HI    (HI),
        .HOLD_LO    (LO),
        .EE_OPCODE  (EE)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .opcode     (opcode),
        .data_in    (data_in),
        .ds         (ds),
        .re         (re),
        .clr_ovf    (clr_ovf),
        .data_out   (data_out),
        .valid      (valid),
        .data_count (data_count),
        .empty      (empty),
        .full       (full),
        .hold       (hold),
        .ee_count   (ee_count),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: the stored words as a queue plus the few flags.
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_dout  = '0;
    bit           m_valid = 1'b0;
    bit           m_hold  = 1'b0;
    bit           m_ovf   = 1'b0;

    function automatic int unsigned m_ee();
        int unsigned n = 0;
        logic [W-1:0] w;
        foreach (m_q[i]) begin
            w = m_q[i];
            if (w[W-1:DW] == EE) n++;
        end
        return n;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        int unsigned sz;
        bit          fl;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_hold  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            sz = m_q.size();
            fl = (sz == DEPTH);
            if (sz >= HI) m_hold = 1'b1;
            else if (sz <= LO) m_hold = 1'b0;
            if (ds && fl) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (re && sz > 0) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (ds && !fl) m_q.push_back({opcode, data_in});
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            cmp("data_count", 32'(data_count), 32'(m_q.size()));
            cmp("empty",      32'(empty),      32'(m_q.size() == 0));
            cmp("full",       32'(full),       32'(m_q.size() == DEPTH));
            cmp("ee_count",   32'(ee_count),   32'(m_ee()));
            cmp("hold",       32'(hold),       32'(m_hold));
            cmp("overflow",   32'(overflow),   32'(m_ovf));
            cmp("valid",      32'(valid),      32'(m_valid));
            cmp("data_out",   32'(data_out),   32'(m_dout));
        end
    end

    task automatic drive(input bit d, input logic [OW-1:0] op, input logic [DW-1:0] dat,
                         input bit r, input bit c);
        @(negedge clk);
        ds      = d;
        opcode  = op;
        data_in = dat;
        re      = r;
        clr_ovf = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [OW-1:0] op, input logic [DW-1:0] dat);
        drive(1'b1, op, dat, 1'b0, 1'b0);
    endtask

    task automatic rd();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_q.size() == 0) break;
            rd();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        cmp("rst_count", 32'(data_count), 32'd0);
        cmp("rst_empty", 32'(empty), 32'd1);
        cmp("rst_full", 32'(full), 32'd0);
        cmp("rst_dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;

        // Three writes then three reads.
        wr(5'h0, 23'h1);
        wr(5'h0, 23'h2);
        wr(5'h0, 23'h3);
        rd();
        rd();
        cmp("seq_v1", 32'(valid), 32'd1);
        cmp("seq_d1", 32'(data_out), 32'h1);
        rd();
        cmp("seq_d2", 32'(data_out), 32'h2);
        idle();
        cmp("seq_d3", 32'(data_out), 32'h3);
        cmp("seq_cnt0", 32'(data_count), 32'd0);
        cmp("seq_empty", 32'(empty), 32'd1);
        idle();
        cmp("seq_v0", 32'(valid), 32'd0);
        cmp("seq_hold_d3", 32'(data_out), 32'h3);

        // Fill past full, overflow, clear collision, clear.
        for (int i = 1; i <= 17; i++) wr(5'h0, 23'(i));
        cmp("full_at16", 32'(full), 32'd1);
        cmp("full_cnt", 32'(data_count), 32'd16);
        cmp("full_ovf0", 32'(overflow), 32'd0);
        idle();
        cmp("drop_ovf1", 32'(overflow), 32'd1);
        cmp("drop_cnt", 32'(data_count), 32'd16);
        drive(1'b1, 5'h0, 23'd99, 1'b0, 1'b1);
        idle();
        cmp("ovf_set_wins", 32'(overflow), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        idle();
        cmp("ovf_clr", 32'(overflow), 32'd0);
        drain();

        // Hold hysteresis.
        for (int i = 0; i < 12; i++) wr(5'h2, 23'(200 + i));
        idle();
        cmp("hold_cnt12", 32'(data_count), 32'd12);
        cmp("hold_lag", 32'(hold), 32'd0);
        idle();
        cmp("hold_set", 32'(hold), 32'd1);
        for (int i = 0; i < 7; i++) rd();
        idle();
        cmp("hold_cnt5", 32'(data_count), 32'd5);
        cmp("hold_keep5", 32'(hold), 32'd1);
        rd();
        idle();
        cmp("hold_cnt4", 32'(data_count), 32'd4);
        cmp("hold_keep4", 32'(hold), 32'd1);
        idle();
        cmp("hold_rel", 32'(hold), 32'd0);
        drain();

        // End-of-event accounting.
        wr(5'h0, 23'd1);
        wr(EE,   23'd2);
        wr(5'h0, 23'd3);
        wr(5'h0, 23'd4);
        wr(EE,   23'd5);
        wr(5'h0, 23'd6);
        idle();
        cmp("ee_two", 32'(ee_count), 32'd2);
        rd();
        rd();
        idle();
        cmp("ee_pop", 32'(ee_count), 32'd1);
        rd();
        rd();
        idle();
        cmp("ee_cnt2", 32'(data_count), 32'd2);
        drive(1'b1, EE, 23'd7, 1'b1, 1'b0);
        idle();
        cmp("ee_both", 32'(ee_count), 32'd1);
        cmp("ee_both_cnt", 32'(data_count), 32'd2);
        drain();

        // Steady state at count 8 across pointer wrap.
        for (int i = 0; i < 8; i++) wr(5'h3, 23'(300 + i));
        for (int i = 0; i < 20; i++) drive(1'b1, 5'h4, 23'(400 + i), 1'b1, 1'b0);
        idle();
        cmp("steady_cnt8", 32'(data_count), 32'd8);
        drain();

        // Randomized phases: write-heavy, read-heavy, balanced.
        for (int p = 0; p < 3; p++) begin
            int unsigned pw;
            int unsigned pr;
            pw = (p == 0) ? 70 : (p == 1) ? 30 : 50;
            pr = (p == 0) ? 30 : (p == 1) ? 70 : 50;
            for (int i = 0; i < 600; i++) begin
                drive($urandom_range(0, 99) < pw,
                      ($urandom_range(0, 3) == 0) ? EE : OW'($urandom),
                      DW'($urandom),
                      $urandom_range(0, 99) < pr,
                      $urandom_range(0, 31) == 0);
            end
        end
        idle();
        drain();

        // Asynchronous reset at count 10 with hold asserted.
        for (int i = 0; i < 13; i++) wr(EE, 23'(500 + i));
        idle();
        idle();
        for (int i = 0; i < 3; i++) rd();
        idle();
        cmp("pre_rst_cnt", 32'(data_count), 32'd10);
        cmp("pre_rst_hold", 32'(hold), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_cnt", 32'(data_count), 32'd0);
        cmp("arst_empty", 32'(empty), 32'd1);
        cmp("arst_full", 32'(full), 32'd0);
        cmp("arst_hold", 32'(hold), 32'd0);
        cmp("arst_ee", 32'(ee_count), 32'd0);
        cmp("arst_valid", 32'(valid), 32'd0);
        cmp("arst_ovf", 32'(overflow), 32'd0);
        cmp("arst_dout", 32'(data_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd();
        idle();
        cmp("post_rst_valid", 32'(valid), 32'd0);
        cmp("post_rst_cnt", 32'(data_count), 32'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gf_hit_fifo

// File: doc/gf_hit_fifo.md
GF_HIT_FIFO -- requirements
Module: gf_hit_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 23: hit data width.
REQ-002 SHALL have parameter OP_W, default 5: opcode width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: log2 of the storage depth; DEPTH = 2**DEPTH_LOG2.
REQ-004 SHALL have parameter HOLD_HI, default DEPTH-64: hold assert threshold, in words.
REQ-005 SHALL have parameter HOLD_LO, default DEPTH/2: hold release threshold; HOLD_LO < HOLD_HI <= DEPTH.
REQ-006 SHALL have parameter EE_OPCODE, default 5'h1F: end-of-event opcode value.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port opcode, input, OP_W: opcode of the incoming word.
REQ-010 SHALL have port data_in, input, DATA_W: data of the incoming word.
REQ-011 SHALL have port ds, input, 1: data strobe; writes {opcode,data_in} this cycle.
REQ-012 SHALL have port re, input, 1: read request.
REQ-013 SHALL have port clr_ovf, input, 1: clears the overflow flag.
REQ-014 SHALL have port data_out, output, OP_W+DATA_W: read word, {opcode,data}.
REQ-015 SHALL have port valid, output, 1: data_out is valid this cycle.
REQ-016 SHALL have port data_count, output, DEPTH_LOG2+1: stored word count.
REQ-017 SHALL have ports empty and full, output, 1 each: count==0 and count==DEPTH.
REQ-018 SHALL have port hold, output, 1: upstream back-pressure.
REQ-019 SHALL have port ee_count, output, DEPTH_LOG2+1: number of stored EE words.
REQ-020 SHALL have port overflow, output, 1: sticky flag set by a dropped write.

Function
REQ-021 A ds write SHALL be accepted iff full==0, regardless of re; the write and read pointers SHALL wrap modulo DEPTH.
REQ-022 A ds write when full==1 SHALL be dropped, with no change to pointers or counts, and SHALL set overflow on the next edge.
REQ-023 A read SHALL pop iff re==1 and empty==0; the popped word SHALL appear on data_out with valid=1 exactly 1 cycle later.
REQ-024 re with empty==1 SHALL be ignored; valid=0 on the next cycle; data_out SHALL hold its last value.
REQ-025 An accepted write and a pop in the same cycle SHALL leave data_count unchanged; otherwise data_count SHALL change by +1 or -1.
REQ-026 data_count, empty and full SHALL be registered and SHALL reflect the operations of the previous edge.
REQ-027 ee_count SHALL increment on an accepted write with opcode==EE_OPCODE and SHALL decrement on a pop of a word whose opcode==EE_OPCODE; when both occur in the same cycle it SHALL be unchanged.
REQ-028 hold SHALL be registered: set when data_count>=HOLD_HI, cleared when data_count<=HOLD_LO, held between those thresholds (hysteresis); latency 1 cycle after data_count changes.
REQ-029 When clr_ovf and a dropped write coincide, overflow SHALL remain 1 (set wins).
REQ-030 A write to an empty FIFO SHALL be readable (re accepted) on the cycle after the write; there is no bypass path.

Reset
REQ-031 While reset==0, pointers, data_count, ee_count, valid, hold, overflow and full SHALL be 0, empty SHALL be 1, and data_out SHALL be all zeros; storage contents are don't-care.
REQ-032 Reset asserted mid-operation SHALL discard all stored words immediately; the first edge after deassertion SHALL behave as an empty FIFO.

Structure
REQ-033 Package gf_pkg SHALL hold the default DATA_W, OP_W and EE_OPCODE constants, shared with the gigafitter top.
REQ-034 Storage SHALL be one sub-module gf_dpram (simple dual-port: synchronous write, registered read, width OP_W+DATA_W, depth DEPTH); all control logic SHALL stay in gf_hit_fifo.

Verification (bench parameters: DEPTH_LOG2=4, HOLD_HI=12, HOLD_LO=4)
REQ-035 Reset, then 3 ds writes (0x000001..0x000003, opcode 0), then re for 3 cycles -> valid on the 3 following cycles with data 1,2,3 in order; data_count returns to 0; empty=1.
REQ-036 17 consecutive ds writes -> full=1 at count 16; the 17th write is dropped and overflow=1; clr_ovf pulse -> overflow=0.
REQ-037 Write 12 words -> hold=1 one cycle after count=12; read down to count 5 -> hold stays 1; at count 4 -> hold=0 one cycle later.
REQ-038 Simultaneous ds and re at count 8, held for 20 cycles -> data_count stays 8; read order is preserved across pointer wrap.
REQ-039 Write 2 words with opcode 0x1F interleaved among 4 others -> ee_count=2; popping the first EE word -> ee_count=1; simultaneous EE write and EE pop -> unchanged.
REQ-040 Assert reset with count=10 and hold=1 -> all outputs take their reset values asynchronously; after release, re -> valid=0.
